fft_ctrl_seq: RTL and testbench
===============================

# fft_ctrl_seq

Parametrised control sequencer for the FFT datapath, generalising the 5-bit valid-gated control counter. Counts point indices within a 2^CNT_W-point frame while `valid` is high, with a selectable idle behaviour (clear or hold), a synchronous clear, and frame-boundary and frame-count outputs. It also drives per-stage butterfly select bits, each delayed to line up with that stage's pipeline latency. It sits between the sample input handshake and the butterfly stage chain.

## Interface
- CNT_W, 5, counter width; frame length = 2^CNT_W points
- NUM_STG, 5, number of butterfly stages controlled (1..CNT_W)
- STG_LAT, 1, pipeline latency in cycles of one butterfly stage (≥0)
- FRM_W, 8, frame counter width

- clk  in  1  clock, all state on rising edge
- rstn  in  1  asynchronous active-low reset
- valid  in  1  sample-valid qualifier
- mode_hold  in  1  0: clear count when valid low (legacy); 1: hold count when valid low
- sync_clr  in  1  synchronous clear of count, frame state and frame counter
- cnt_ctrl  out  CNT_W  registered point index
- frame_last  out  1  registered one-cycle pulse, frame completed
- frame_cnt  out  FRM_W  completed-frame count, wraps
- stg_sel  out  NUM_STG  per-stage butterfly select
- stg_vld  out  NUM_STG  per-stage valid, aligned with stg_sel

## Operation
- Reset (rstn=0, async): cnt_ctrl=0, frame_last=0, frame_cnt=0, all delay-line registers 0, so stg_sel=0 and stg_vld=0.
- Next-state priority per edge:
  1. sync_clr=1: cnt_ctrl←0, frame_cnt←0, frame_last←0. Delay lines keep shifting.
  2. valid=1: cnt_ctrl←cnt_ctrl+1, modulo 2^CNT_W.
  3. valid=0: cnt_ctrl←0 if mode_hold=0, else cnt_ctrl unchanged.
- Index semantics: a sample presented with valid=1 in cycle t has index cnt_ctrl(t).
  - The first valid after reset or a clear sees index 0.
- Wrap: at valid=1 with cnt_ctrl=2^CNT_W−1 and sync_clr=0:
  - cnt_ctrl←0, frame_last←1, frame_cnt←frame_cnt+1 (modulo 2^FRM_W).
  - Otherwise frame_last←0.
- mode_hold=0 breaks a frame on any valid gap; no frame_last for partial frames.
- mode_hold may change at any cycle; it takes effect on the next edge.
- Stage control: let raw_sel[k] = cnt_ctrl[CNT_W−1−k] gated by valid, and raw_vld = valid.
  - stg_sel[k] = raw_sel[k] delayed k·STG_LAT cycles.
  - stg_vld[k] = raw_vld delayed k·STG_LAT cycles.
  - Stage 0 is combinational passthrough; all other taps are registered.
- Delay lines shift every cycle regardless of valid or sync_clr. Only rstn clears them.

## Timing
- cnt_ctrl: 1-cycle update latency from valid, same as the legacy counter.
- frame_last: asserted in the same cycle cnt_ctrl shows 0 after the wrap; high for exactly one cycle.
- stg_sel[k] / stg_vld[k]: latency k·STG_LAT from the cycle the sample was presented. No backpressure; no stall input.
- Reset asserted mid-frame: all outputs go to 0 immediately (async); in-flight stage controls are discarded.
- Reset deassertion: the first counting edge is the first rising clk with rstn=1.
- Simultaneous sync_clr and wrap: clear wins, so there is no frame_last pulse and no frame_cnt increment.
- frame_cnt wraps 2^FRM_W−1 → 0 silently.

## Structure
- Package fft_ctrl_pkg holds:
  - default constants FFT_CNT_W=5, FFT_NUM_STG=5, FFT_STG_LAT=1;
  - typedef for the point index (logic [FFT_CNT_W-1:0]).
- Sub-module ctrl_dly_line: parametrised width/depth shift register with async active-low reset to 0, and passthrough when depth=0. Instantiate once per stage via generate, width 2 (sel, vld).
- Elaboration assertion: 1 ≤ NUM_STG ≤ CNT_W.

## Test plan
- Reset mid-count: count to 13, assert rstn=0 for one half-cycle → cnt_ctrl, frame_last, frame_cnt, stg_sel, stg_vld all 0 immediately; first valid edge after release gives cnt_ctrl=1.
- Legacy mode (mode_hold=0): valid high 10 cycles, low 1, high 3 → cnt_ctrl reaches 10, drops to 0, then 1,2,3; no frame_last.
- Hold mode (mode_hold=1): valid high 10, low 4, high 22 → cnt_ctrl holds 10 during the gap; wraps to 0 with frame_last=1 for one cycle; frame_cnt=1.
- Continuous valid 96 cycles, CNT_W=5 → exactly 3 frame_last pulses, at cycles 32/64/96 after the first valid edge; frame_cnt=3.
- sync_clr asserted together with valid when cnt_ctrl=31 → next cnt_ctrl=0, frame_last=0, frame_cnt=0.
- STG_LAT=2, single valid at cnt_ctrl=16 (0b10000) → stg_sel[0]=1 in the same cycle; stg_vld[k] pulses at cycle +2k; stg_sel[1..4]=0 at their aligned cycles.

Source files
------------

// File: rtl/fft_ctrl_pkg.sv
// fft_ctrl_pkg
// Shared constants and types for the FFT control sequencer.
//   FFT_CNT_W   : default point-index width (frame = 2^FFT_CNT_W points)
//   FFT_NUM_STG : default number of butterfly stages driven
//   FFT_STG_LAT : default per-stage pipeline latency in cycles
//   FFT_FRM_W   : default completed-frame counter width
//   pt_idx_t    : point index at the default width
package fft_ctrl_pkg;

  localparam int FFT_CNT_W   = 5;
  localparam int FFT_NUM_STG = 5;
  localparam int FFT_STG_LAT = 1;
  localparam int FFT_FRM_W   = 8;

  typedef logic [FFT_CNT_W-1:0] pt_idx_t;

endpackage : fft_ctrl_pkg

// File: rtl/ctrl_dly_line.sv
// ctrl_dly_line
// Fixed-depth shift register for stage control bits. DEPTH=0 is a plain
// combinational passthrough, so stage 0 of the sequencer needs no special case.
// Ports:
//   clk  : clock, shifts on every rising edge (no enable)
//   rstn : asynchronous active-low reset, clears every tap to 0
//   din  : WIDTH-bit input
//   dout : din delayed by DEPTH cycles
module ctrl_dly_line
  import fft_ctrl_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int DEPTH = FFT_STG_LAT
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DEPTH == 0) begin : g_pass
    // Clock and reset have no function without storage.
    logic unused_clk_rst;
    assign unused_clk_rst = &{1'b0, clk, rstn};
    assign dout = din;
  end else begin : g_sr
    logic [WIDTH-1:0] sr [DEPTH];

    // NOTE: this array is a handful of flops, not a RAM, so it is reset;
    // stale stage controls must never leak out after rstn.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
      end else begin
        sr[0] <= din;
        for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
      end
    end

    assign dout = sr[DEPTH-1];
  end

endmodule : ctrl_dly_line

// File: rtl/fft_ctrl_seq.sv
// fft_ctrl_seq
// Control sequencer for the FFT datapath. Counts point indices within a
// 2^CNT_W-point frame while valid is high, flags frame completion, counts
// frames, and emits per-stage butterfly select/valid bits, each delayed by
// k*STG_LAT cycles to line up with stage k of the pipeline.
// Ports:
//   clk        : clock
//   rstn       : asynchronous active-low reset
//   valid      : sample-valid qualifier
//   mode_hold  : 0 clears the count on a valid gap, 1 holds it
//   sync_clr   : synchronous clear of count, frame_last and frame_cnt
//   cnt_ctrl   : registered point index of the sample presented this cycle
//   frame_last : one-cycle pulse, the previous edge completed a frame
//   frame_cnt  : completed-frame count, wraps silently
//   stg_sel    : per-stage butterfly select
//   stg_vld    : per-stage valid, aligned with stg_sel
module fft_ctrl_seq
  import fft_ctrl_pkg::*;
#(
  parameter int CNT_W   = FFT_CNT_W,
  parameter int NUM_STG = FFT_NUM_STG,
  parameter int STG_LAT = FFT_STG_LAT,
  parameter int FRM_W   = FFT_FRM_W
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               valid,
  input  logic               mode_hold,
  input  logic               sync_clr,
  output logic [CNT_W-1:0]   cnt_ctrl,
  output logic               frame_last,
  output logic [FRM_W-1:0]   frame_cnt,
  output logic [NUM_STG-1:0] stg_sel,
  output logic [NUM_STG-1:0] stg_vld
);

  if (NUM_STG < 1 || NUM_STG > CNT_W) begin : g_bad_num_stg
    $error("fft_ctrl_seq: NUM_STG must be in 1..CNT_W");
  end

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values of the others, whatever the statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_ctrl   <= '0;
      frame_last <= 1'b0;
      frame_cnt  <= '0;
    end else if (sync_clr) begin
      // Clear beats a coincident wrap: no pulse, no frame increment.
      cnt_ctrl   <= '0;
      frame_last <= 1'b0;
      frame_cnt  <= '0;
    end else if (valid) begin
      cnt_ctrl <= cnt_ctrl + CNT_W'(1);
      if (cnt_ctrl == CNT_MAX) begin
        frame_last <= 1'b1;
        frame_cnt  <= frame_cnt + FRM_W'(1);
      end else begin
        frame_last <= 1'b0;
      end
    end else begin
      // Legacy behaviour drops a partial frame on any gap.
      if (!mode_hold) cnt_ctrl <= '0;
      frame_last <= 1'b0;
    end
  end

  // Stage k butterflies on index bit CNT_W-1-k (MSB first), gated by valid.
  logic [NUM_STG-1:0] raw_sel;

  // NOTE: every always_comb output gets a default before any conditional
  // logic, so no path can leave it unassigned and infer a latch.
  always_comb begin
    raw_sel = '0;
    for (int k = 0; k < NUM_STG; k++) raw_sel[k] = valid & cnt_ctrl[CNT_W-1-k];
  end

  logic [1:0] dly_out [NUM_STG];

  for (genvar k = 0; k < NUM_STG; k++) begin : g_stg
    ctrl_dly_line #(
      .WIDTH (2),
      .DEPTH (k * STG_LAT)
    ) u_dly (
      .clk  (clk),
      .rstn (rstn),
      .din  ({raw_sel[k], valid}),
      .dout (dly_out[k])
    );
  end

  always_comb begin
    stg_sel = '0;
    stg_vld = '0;
    for (int k = 0; k < NUM_STG; k++) begin
      stg_sel[k] = dly_out[k][1];
      stg_vld[k] = dly_out[k][0];
    end
  end

endmodule : fft_ctrl_seq

// File: tb/tb_fft_ctrl_seq.sv
// tb_fft_ctrl_seq
// Directed bench for fft_ctrl_seq. Two instances share all inputs: u_dut uses
// the default STG_LAT=1, u_dut2 uses STG_LAT=2. Inputs change 1 ns after a
// rising edge; outputs are checked 1 ns after that.
module tb_fft_ctrl_seq;
  import fft_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rstn;
  logic       valid;
  logic       mode_hold;
  logic       sync_clr;

  pt_idx_t    cnt_ctrl,   cnt_ctrl2;
  logic       frame_last, frame_last2;
  logic [7:0] frame_cnt,  frame_cnt2;
  logic [4:0] stg_sel,    stg_sel2;
  logic [4:0] stg_vld,    stg_vld2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fft_ctrl_seq #(.CNT_W(5), .NUM_STG(5), .STG_LAT(1), .FRM_W(8)) u_dut (
    .clk        (clk),
    .rstn       (rstn),
    .valid      (valid),
    .mode_hold  (mode_hold),
    .sync_clr   (sync_clr),
    .cnt_ctrl   (cnt_ctrl),
    .frame_last (frame_last),
    .frame_cnt  (frame_cnt),
    .stg_sel    (stg_sel),
    .stg_vld    (stg_vld)
  );

  fft_ctrl_seq #(.CNT_W(5), .NUM_STG(5), .STG_LAT(2), .FRM_W(8)) u_dut2 (
    .clk        (clk),
    .rstn       (rstn),
    .valid      (valid),
    .mode_hold  (mode_hold),
    .sync_clr   (sync_clr),
    .cnt_ctrl   (cnt_ctrl2),
    .frame_last (frame_last2),
    .frame_cnt  (frame_cnt2),
    .stg_sel    (stg_sel2),
    .stg_vld    (stg_vld2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_seq();
    sync_clr = 1'b1;
    valid    = 1'b0;
    tick();
    sync_clr = 1'b0;
  endtask

  // Expected stage outputs m cycles after a lone valid sample with index cnt.
  function automatic logic [4:0] exp_sel(input int cnt, input int lat, input int m);
    logic [4:0] r = '0;
    for (int k = 0; k < 5; k++) if (k * lat == m) r[k] = cnt[4-k];
    return r;
  endfunction

  function automatic logic [4:0] exp_vld(input int lat, input int m);
    logic [4:0] r = '0;
    for (int k = 0; k < 5; k++) if (k * lat == m) r[k] = 1'b1;
    return r;
  endfunction

  // Single valid pulse with the current held index, then watch it ripple.
  task automatic stage_pulse(input int cnt);
    valid = 1'b1;
    #1;
    check("stg_sel_m0",  32'(stg_sel),  32'(exp_sel(cnt, 1, 0)));
    check("stg_vld_m0",  32'(stg_vld),  32'(exp_vld(1, 0)));
    check("stg_sel2_m0", 32'(stg_sel2), 32'(exp_sel(cnt, 2, 0)));
    check("stg_vld2_m0", 32'(stg_vld2), 32'(exp_vld(2, 0)));
    tick();
    valid = 1'b0;
    for (int m = 1; m <= 9; m++) begin
      #1;
      check("stg_sel_m",  32'(stg_sel),  32'(exp_sel(cnt, 1, m)));
      check("stg_vld_m",  32'(stg_vld),  32'(exp_vld(1, m)));
      check("stg_sel2_m", 32'(stg_sel2), 32'(exp_sel(cnt, 2, m)));
      check("stg_vld2_m", 32'(stg_vld2), 32'(exp_vld(2, m)));
      tick();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int pulses;
    rstn      = 1'b0;
    valid     = 1'b0;
    mode_hold = 1'b0;
    sync_clr  = 1'b0;
    #2;
    check("rst_cnt",        32'(cnt_ctrl),   32'd0);
    check("rst_frame_last", 32'(frame_last), 32'd0);
    check("rst_frame_cnt",  32'(frame_cnt),  32'd0);
    check("rst_stg_vld",    32'(stg_vld),    32'd0);
    #10 rstn = 1'b1;

    // Reset mid-count.
    tick();
    mode_hold = 1'b1;
    valid     = 1'b1;
    for (int i = 0; i < 13; i++) tick();
    check("pre_rst_cnt", 32'(cnt_ctrl), 32'd13);
    check("pre_rst_vld2", 32'(stg_vld2), 32'h1f);
    @(negedge clk);
    valid = 1'b0;
    rstn  = 1'b0;
    #1;
    check("mid_rst_cnt",        32'(cnt_ctrl),   32'd0);
    check("mid_rst_frame_last", 32'(frame_last), 32'd0);
    check("mid_rst_frame_cnt",  32'(frame_cnt),  32'd0);
    check("mid_rst_stg_sel",    32'(stg_sel2),   32'd0);
    check("mid_rst_stg_vld",    32'(stg_vld2),   32'd0);
    #3;
    rstn  = 1'b1;
    valid = 1'b1;
    tick();
    check("post_rst_cnt", 32'(cnt_ctrl), 32'd1);

    // Legacy mode: 10 valid, 1 gap, 3 valid.
    mode_hold = 1'b0;
    clear_seq();
    check("clr_cnt", 32'(cnt_ctrl), 32'd0);
    valid = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      check("leg_cnt", 32'(cnt_ctrl), 32'(i));
      check("leg_fl",  32'(frame_last), 32'd0);
    end
    valid = 1'b0;
    tick();
    check("leg_gap_cnt", 32'(cnt_ctrl), 32'd0);
    valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("leg_resume_cnt", 32'(cnt_ctrl), 32'(i));
      check("leg_resume_fl",  32'(frame_last), 32'd0);
    end

    // Hold mode: 10 valid, 4 gap, 22 valid.
    mode_hold = 1'b1;
    clear_seq();
    valid = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check("hold_pre_cnt", 32'(cnt_ctrl), 32'd10);
    valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("hold_gap_cnt", 32'(cnt_ctrl), 32'd10);
    end
    valid = 1'b1;
    for (int j = 1; j <= 21; j++) tick();
    check("hold_cnt31", 32'(cnt_ctrl),   32'd31);
    check("hold_fl31",  32'(frame_last), 32'd0);
    tick();
    check("hold_wrap_cnt", 32'(cnt_ctrl),   32'd0);
    check("hold_wrap_fl",  32'(frame_last), 32'd1);
    check("hold_wrap_fc",  32'(frame_cnt),  32'd1);
    valid = 1'b0;
    tick();
    check("hold_fl_off", 32'(frame_last), 32'd0);
    check("hold_fc",     32'(frame_cnt),  32'd1);

    // Continuous valid for three frames.
    clear_seq();
    check("clr_fc", 32'(frame_cnt), 32'd0);
    valid  = 1'b1;
    pulses = 0;
    for (int i = 1; i <= 96; i++) begin
      tick();
      check("cont_cnt", 32'(cnt_ctrl),   32'(i % 32));
      check("cont_fl",  32'(frame_last), 32'((i % 32) == 0));
      if (frame_last) pulses++;
    end
    check("cont_pulses", 32'(pulses),    32'd3);
    check("cont_fc",     32'(frame_cnt), 32'd3);

    // sync_clr coincident with a wrap.
    for (int i = 0; i < 31; i++) tick();
    check("clrwrap_pre_cnt", 32'(cnt_ctrl),  32'd31);
    check("clrwrap_pre_fc",  32'(frame_cnt), 32'd3);
    sync_clr = 1'b1;
    tick();
    sync_clr = 1'b0;
    valid    = 1'b0;
    check("clrwrap_cnt", 32'(cnt_ctrl),   32'd0);
    check("clrwrap_fl",  32'(frame_last), 32'd0);
    check("clrwrap_fc",  32'(frame_cnt),  32'd0);

    // Frame counter wraps 255 -> 0.
    valid = 1'b1;
    for (int i = 0; i < 255 * 32; i++) tick();
    check("fc_255", 32'(frame_cnt), 32'd255);
    for (int i = 0; i < 32; i++) tick();
    check("fc_wrap",    32'(frame_cnt),  32'd0);
    check("fc_wrap_fl", 32'(frame_last), 32'd1);

    // Stage alignment: index 16 (0b10000), then 17 (0b10001).
    clear_seq();
    valid = 1'b1;
    for (int i = 0; i < 16; i++) tick();
    valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("stg_idle_vld2", 32'(stg_vld2), 32'd0);
    check("stg_cnt16",     32'(cnt_ctrl2), 32'd16);
    stage_pulse(16);
    check("stg_cnt17", 32'(cnt_ctrl2), 32'd17);
    stage_pulse(17);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_fft_ctrl_seq
